microwave_btn_debounce: RTL and testbench
=========================================

Name: microwave_btn_debounce

Overview:
- Parametrised multi-channel push-button conditioner. Successor to the single enable-gated debounce flop.
- Per channel: 2-FF synchroniser, internal sample-tick divider, N-consecutive-sample stability filter, one-cycle rise/fall pulses and a long-press pulse.
- Sits between the FPGA button pins and the microwave/air-conditioner control FSMs. The control FSMs use only the clean levels and pulses.

Parameters:
- N_CH, 5: number of independent button channels (>=1).
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- TICK_HZ, 1000: sample-tick rate. DIV = CLK_HZ/TICK_HZ (integer, >=1).
- STABLE_CNT, 4: consecutive differing samples required to accept a new level (>=1).
- LONG_TICKS, 1000: ticks of continuous pressed level before btn_long fires (>=1).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- btn_raw, input, N_CH: asynchronous raw button inputs, active-high.
- btn_level, output, N_CH: debounced level per channel.
- btn_rise, output, N_CH: one-clk pulse on each debounced 0->1.
- btn_fall, output, N_CH: one-clk pulse on each debounced 1->0.
- btn_long, output, N_CH: one-clk pulse when a press reaches LONG_TICKS.
- tick, output, 1: one-clk sample-tick strobe, exported for other blocks.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchroniser flops, divider, stable counters, hold counters = 0.
  - btn_level, btn_rise, btn_fall, btn_long, tick = 0.
  - Release is synchronous to clk (first active edge after reset_n rises).
- Synchroniser: sync[i] = btn_raw[i] delayed by 2 flops. This is the only path from btn_raw into the filter.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick=1 (registered) for exactly one cycle when div_cnt==DIV-1, i.e. once every DIV cycles.
  - First tick in cycle DIV after reset release.
  - DIV=1: tick is held high every cycle.
- Stability filter, per channel, evaluated only in tick cycles:
  - If sync[i]==btn_level[i]: stab[i] <= 0.
  - Else, if stab[i]==STABLE_CNT-1: btn_level[i] toggles and stab[i] <= 0.
  - Else: stab[i] <= stab[i]+1.
  - A change is accepted only after STABLE_CNT consecutive differing ticks. Any equal sample in between clears progress; glitches shorter than that are rejected.
  - STABLE_CNT=1: level follows sync on each tick.
  - Width of stab = $clog2(STABLE_CNT+1).
- Edge pulses:
  - btn_rise[i] / btn_fall[i] are asserted in the same cycle btn_level[i] first shows its new value, for exactly one cycle.
  - Never both high together.
- Long press:
  - hold[i] clears whenever btn_level[i]==0.
  - While btn_level[i]==1, hold[i] increments on each tick and saturates at LONG_TICKS.
  - btn_long[i] pulses one cycle on the tick where hold[i] transitions LONG_TICKS-1 -> LONG_TICKS.
  - Exactly once per press, no auto-repeat. Release and re-press re-arms it.
  - The tick that sets btn_level to 1 does not count; counting starts from the next tick.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- Reset mid-operation: all state is lost immediately. A button held through reset produces a fresh btn_rise after STABLE_CNT ticks.
- Latency, raw edge to level change: 2 cycles (synchroniser) + wait to next tick + (STABLE_CNT-1)*DIV + 1 cycle.
- Illegal parameters (DIV<1, STABLE_CNT<1, LONG_TICKS<1) are rejected with an elaboration-time $error.

Test Plan:
- Sim parameters CLK_HZ=100, TICK_HZ=10 (DIV=10), STABLE_CNT=4, LONG_TICKS=20, N_CH=3.
- Reset behaviour: hold reset_n=0 with btn_raw=3'b111 -> all outputs 0. Release -> tick first at cycle 10. btn_level=3'b111 after 4 ticks. btn_rise=3'b111 for exactly 1 cycle.
- Glitch rejection: ch0 high for 3 tick periods (30 cycles), then low -> btn_level[0] stays 0, no pulses. Repeat with 5 periods -> btn_rise[0] on the 4th tick, btn_fall[0] 4 ticks after release.
- Bounce: ch1 toggles every 7 cycles for 100 cycles, then stays 1 -> exactly one btn_rise[1]. Level stable from 4 ticks after the last bounce.
- Long press: ch2 held for 30 ticks -> btn_long[2] exactly once, 20 ticks after btn_rise[2]. No repeat. Release and re-press -> fires again.
- Independence and async reset: ch0 pressed while ch1 is released in the same cycle -> btn_rise[0] and btn_fall[1] in the same cycle. Assert reset_n=0 mid-press, asynchronously between clk edges -> outputs clear before the next clk edge.
- DIV=1 variant (TICK_HZ=100): tick is constant 1. Level changes 2+4 cycles after a clean raw edge.

Source files
------------

// File: rtl/microwave_btn_debounce.sv
// Multi-channel push-button conditioner: per-lane 2-FF synchroniser, tick-gated
// stability filter, registered rise/fall/long-press pulses, and a shared sample-tick divider.

module microwave_btn_debounce_ch #(
  parameter int STABLE_CNT = 4,
  parameter int LONG_TICKS = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PEN  = HW'(LONG_TICKS - 1);

  logic [1:0]    sync_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          long_q, long_d;
  logic          sync_s;

  assign sync_s = sync_q[1];

  always_comb begin
    stab_d  = stab_q;
    level_d = level_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    if (tick_i) begin
      if (sync_s == level_q) begin
        stab_d = '0;
      end else if (stab_q == STAB_LAST) begin
        level_d = ~level_q;
        stab_d  = '0;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
    // Hold counts from the tick after the level went high; the accepting tick sees level_q=0.
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_PEN);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;
endmodule

module microwave_btn_debounce #(
  parameter int N_CH       = 5,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int STABLE_CNT = 4,
  parameter int LONG_TICKS = 1000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long,
  output logic            tick
);
  localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((DIV > 0) ? DIV - 1 : 0);

  if (DIV < 1) begin : g_bad_div
    $error("microwave_btn_debounce: CLK_HZ/TICK_HZ must be >= 1");
  end
  if (STABLE_CNT < 1) begin : g_bad_stab
    $error("microwave_btn_debounce: STABLE_CNT must be >= 1");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("microwave_btn_debounce: LONG_TICKS must be >= 1");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("microwave_btn_debounce: N_CH must be >= 1");
  end

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;

  // Tick is registered off the terminal count, so it lands on cycle DIV after release.
  always_comb begin
    tick_d    = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick_d ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    microwave_btn_debounce_ch #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_TICKS(LONG_TICKS)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick_i (tick_q),
      .raw_i  (btn_raw[g]),
      .level_o(btn_level[g]),
      .rise_o (btn_rise[g]),
      .fall_o (btn_fall[g]),
      .long_o (btn_long[g])
    );
  end
endmodule

// File: tb/tb_microwave_btn_debounce.sv
// Directed bench: a DIV=1 instance driven from a vector table, and a DIV=10 instance
// exercised with timed sequences whose pulse edges are compared against hand-derived cycle numbers.

module tb_microwave_btn_debounce;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] raw10 = '0, lvl10, rise10, fall10, long10;
  logic [2:0] raw1 = '0, lvl1, rise1, fall1, long1;
  logic tick10, tick1;

  always #5 clk = ~clk;

  microwave_btn_debounce #(.N_CH(3), .CLK_HZ(100), .TICK_HZ(10), .STABLE_CNT(4), .LONG_TICKS(20)) u10 (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw10), .btn_level(lvl10), .btn_rise(rise10),
    .btn_fall(fall10), .btn_long(long10), .tick(tick10));

  microwave_btn_debounce #(.N_CH(3), .CLK_HZ(100), .TICK_HZ(100), .STABLE_CNT(4), .LONG_TICKS(20)) u1 (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw1), .btn_level(lvl1), .btn_rise(rise1),
    .btn_fall(fall1), .btn_long(long1), .tick(tick1));

  typedef struct {
    logic [2:0] raw;
    int         wt;
    logic [2:0] lvl, rise, fall, lng;
  } vec_t;

  vec_t vt [16];
  int n_tests = 0, n_fail = 0, ecnt = 0;
  int rise_cnt [3], fall_cnt [3], long_cnt [3], f_rise [3], f_fall [3], f_long [3];
  int tick_cnt, f_tick, overlap;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 3; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
      f_rise[c] = -1; f_fall[c] = -1; f_long[c] = -1;
    end
    tick_cnt = 0; f_tick = -1; overlap = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    ecnt++;
    if (tick10) begin tick_cnt++; if (f_tick < 0) f_tick = ecnt; end
    for (int c = 0; c < 3; c++) begin
      if (rise10[c]) begin rise_cnt[c]++; if (f_rise[c] < 0) f_rise[c] = ecnt; end
      if (fall10[c]) begin fall_cnt[c]++; if (f_fall[c] < 0) f_fall[c] = ecnt; end
      if (long10[c]) begin long_cnt[c]++; if (f_long[c] < 0) f_long[c] = ecnt; end
      if (rise10[c] && fall10[c]) overlap++;
    end
  endtask

  task automatic step_to(input int n);
    while (ecnt < n) step();
  endtask

  // Asserts reset mid-cycle, checks the clear lands before the next edge, releases on a negedge.
  task automatic do_reset(input logic [2:0] r10, input logic [2:0] r1);
    raw10 = r10; raw1 = r1;
    @(posedge clk); #4;
    reset_n = 1'b0;
    #1 check("async_clear", {lvl10, rise10, fall10, long10, tick10}, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("in_reset", {lvl10, rise10, fall10, long10, tick10, lvl1, rise1, fall1, long1, tick1}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ecnt = 0;
    clear_stats();
  endtask

  initial begin
    vt[0]  = '{3'b000, 3,  3'b000, 3'b000, 3'b000, 3'b000};
    vt[1]  = '{3'b001, 4,  3'b000, 3'b000, 3'b000, 3'b000};
    vt[2]  = '{3'b001, 1,  3'b000, 3'b000, 3'b000, 3'b000};
    vt[3]  = '{3'b001, 1,  3'b001, 3'b001, 3'b000, 3'b000};
    vt[4]  = '{3'b001, 1,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[5]  = '{3'b011, 3,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[6]  = '{3'b001, 6,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[7]  = '{3'b011, 4,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[8]  = '{3'b001, 2,  3'b011, 3'b010, 3'b000, 3'b000};
    vt[9]  = '{3'b001, 3,  3'b011, 3'b000, 3'b000, 3'b000};
    vt[10] = '{3'b001, 1,  3'b001, 3'b000, 3'b010, 3'b001};
    vt[11] = '{3'b001, 1,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[12] = '{3'b001, 20, 3'b001, 3'b000, 3'b000, 3'b000};
    vt[13] = '{3'b100, 5,  3'b001, 3'b000, 3'b000, 3'b000};
    vt[14] = '{3'b100, 1,  3'b100, 3'b100, 3'b001, 3'b000};
    vt[15] = '{3'b100, 1,  3'b100, 3'b000, 3'b000, 3'b000};

    // DIV=1 instance: tick always high, 6-cycle raw-to-level latency
    do_reset(3'b000, 3'b000);
    for (int i = 0; i < 16; i++) begin
      raw1 = vt[i].raw;
      repeat (vt[i].wt) step();
      check($sformatf("div1_vec%0d", i), {lvl1, rise1, fall1, long1, tick1},
            {vt[i].lvl, vt[i].rise, vt[i].fall, vt[i].lng, 1'b1});
    end

    // DIV=10: buttons held through reset
    do_reset(3'b111, 3'b000);
    step_to(40);
    check("rst_lvl_e40", lvl10, 3'b000);
    step_to(60);
    check("rst_first_tick", f_tick, 10);
    check("rst_tick_cnt", tick_cnt, 6);
    check("rst_lvl_e60", lvl10, 3'b111);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst_rise_at_ch%0d", c), f_rise[c], 41);
      check($sformatf("rst_rise_cnt_ch%0d", c), rise_cnt[c], 1);
    end

    // Glitch rejection on ch0: 3 periods rejected, 5 periods accepted
    do_reset(3'b000, 3'b000);
    step_to(14);  raw10[0] = 1'b1;
    step_to(44);  raw10[0] = 1'b0;
    step_to(104);
    check("glitch3_rise_cnt", rise_cnt[0], 0);
    check("glitch3_lvl", lvl10[0], 1'b0);
    raw10[0] = 1'b1;
    step_to(154); raw10[0] = 1'b0;
    step_to(200);
    check("press5_rise_at", f_rise[0], 141);
    check("press5_rise_cnt", rise_cnt[0], 1);
    check("press5_fall_at", f_fall[0], 191);
    check("press5_fall_cnt", fall_cnt[0], 1);

    // Bounce on ch1: toggles every 7 cycles, then settles high
    clear_stats();
    for (int j = 0; j < 14; j++) begin
      raw10[1] = (j % 2 == 0);
      step_to(207 + 7 * j);
      if (j < 13) ecnt = ecnt;
    end
    raw10[1] = 1'b1;
    step_to(360);
    check("bounce_rise_cnt", rise_cnt[1], 1);
    check("bounce_rise_at", f_rise[1], 321);
    check("bounce_fall_cnt", fall_cnt[1], 0);

    // Long press on ch2, then release and re-press
    clear_stats();
    raw10[2] = 1'b1;
    step_to(700); raw10[2] = 1'b0;
    step_to(750);
    check("long_rise_at", f_rise[2], 401);
    check("long_at", f_long[2], 601);
    check("long_cnt", long_cnt[2], 1);
    check("long_fall_at", f_fall[2], 741);
    clear_stats();
    step_to(760); raw10[2] = 1'b1;
    step_to(1020);
    check("repress_rise_at", f_rise[2], 801);
    check("repress_long_at", f_long[2], 1001);
    check("repress_long_cnt", long_cnt[2], 1);

    // Independence: ch0 press and ch1 release in the same cycle
    clear_stats();
    raw10[0] = 1'b1; raw10[1] = 1'b0;
    step_to(1070);
    check("indep_rise0_at", f_rise[0], 1061);
    check("indep_fall1_at", f_fall[1], 1061);
    check("indep_lvl", lvl10, 3'b101);
    check("no_rise_fall_overlap", overlap, 0);

    // Reset mid-press: held buttons must re-rise from scratch
    do_reset(3'b101, 3'b000);
    step_to(60);
    check("rerst_rise0_at", f_rise[0], 41);
    check("rerst_rise2_at", f_rise[2], 41);
    check("rerst_rise1_cnt", rise_cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
